// File: rtl/mode_2_fsm.sv
// Free-running, self-timed sequencer: IDLE -> RUN -> DONE -> GAP -> IDLE.
// Emits a one-cycle registered done tick once per period.
//
// Parameters:
//   RUN_CYCLES  cycles spent in RUN per period (>= 1)
//   GAP_CYCLES  cycles spent in GAP after DONE (>= 1)
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   done   registered completion pulse, high exactly while in DONE
module mode_2_fsm #(
   parameter int RUN_CYCLES = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic done
);

   localparam int MAXC = (RUN_CYCLES > GAP_CYCLES) ?
                         RUN_CYCLES : GAP_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0] RUN_LAST = CW'(RUN_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   // 3-bit encoding leaves spare codes that recover to IDLE.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RUN  = 3'd1,
      S_DONE = 3'd2,
      S_GAP  = 3'd3
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          done_q,  done_d;

   always_comb begin
      state_d = S_IDLE;
      cnt_d   = '0;
      case (state_q)
         S_IDLE: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (cnt_q == RUN_LAST) begin
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         S_DONE: begin
            state_d = S_GAP;
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_GAP;
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // done follows next-state so it aligns with the state register.
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign done = done_q;

endmodule

// File: tb/tb_mode_2_fsm.sv
// Scoreboard bench for mode_2_fsm: default and 1/1 instances.
// Expected pulse edges are queued; a negedge monitor pops and compares.
module tb_mode_2_fsm;

   logic clk;
   logic rst_n;
   logic done_a;
   logic done_b;

   mode_2_fsm #(.RUN_CYCLES(8), .GAP_CYCLES(2)) u_a (
      .clk  (clk),
      .rst_n(rst_n),
      .done (done_a)
   );

   mode_2_fsm #(.RUN_CYCLES(1), .GAP_CYCLES(1)) u_b (
      .clk  (clk),
      .rst_n(rst_n),
      .done (done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int ecnt;
   int qa[$];
   int qb[$];
   bit mon_en = 1'b0;

   // Rising edges since last reset release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ecnt <= 0;
      else        ecnt <= ecnt + 1;
   end

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t edge=%0d: got %0d expected %0d",
                  nm, $time, ecnt, act, exp);
      end
   endtask

   // Monitor: compare every sampled cycle against the queue heads.
   always @(negedge clk) begin
      logic ea;
      logic eb;
      if (mon_en) begin
         ea = (qa.size() > 0) && (qa[0] == ecnt);
         eb = (qb.size() > 0) && (qb[0] == ecnt);
         check("done_a", int'(done_a), int'(ea));
         check("done_b", int'(done_b), int'(eb));
         if (ea) void'(qa.pop_front());
         if (eb) void'(qb.pop_front());
      end
   end

   task automatic run_to(input int n);
      int guard;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (ecnt != n && guard < 200);
      if (ecnt != n) check("run_to_timeout", ecnt, n);
      #2;
   endtask

   task automatic flush_check();
      check("qa_empty", qa.size(), 0);
      check("qb_empty", qb.size(), 0);
      qa.delete();
      qb.delete();
   endtask

   task automatic hold_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #2;
   endtask

   initial begin
      rst_n  = 1'b0;
      mon_en = 1'b1;
      // Reset hold: done low before release.
      #15;
      check("reset_a", int'(done_a), 0);
      check("reset_b", int'(done_b), 0);
      // Defaults: pulses at 9, 21, 33. 1/1: at 2, then every 4.
      qa = '{9, 21, 33};
      for (int e = 2; e <= 40; e += 4) qb.push_back(e);
      #5;
      rst_n = 1'b1;
      run_to(40);
      flush_check();

      // Mid-run reset at edge 5.
      hold_reset();
      qb.push_back(2);
      rst_n = 1'b1;
      run_to(5);
      rst_n = 1'b0;
      #1;
      check("midrun_a", int'(done_a), 0);
      check("midrun_b", int'(done_b), 0);
      flush_check();
      repeat (2) @(negedge clk);
      #2;
      qa = '{9, 21};
      for (int e = 2; e <= 24; e += 4) qb.push_back(e);
      rst_n = 1'b1;
      run_to(24);
      flush_check();

      // Async reset while done is high.
      hold_reset();
      qa = '{9};
      qb = '{2, 6};
      rst_n = 1'b1;
      run_to(9);
      check("pulse_high", int'(done_a), 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_drop", int'(done_a), 0);
      flush_check();
      mon_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
